// File: rtl/ov7670_stream_pkg.sv
// Shared state/pattern types and RGB565 colour constants for the OV7670 stream generator.
package ov7670_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_VSYNC   = 3'd1,
    ST_V_BP    = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_H_BLANK = 3'd4,
    ST_V_FP    = 3'd5
  } gen_state_t;

  typedef enum logic [1:0] {
    PAT_BARS     = 2'd0,
    PAT_GRADIENT = 2'd1,
    PAT_SOLID    = 2'd2,
    PAT_CHECKER  = 2'd3
  } pattern_t;

  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_BLACK = 16'h0000;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = BAR_WHITE;
      3'd1:    bar_color = BAR_YELLOW;
      3'd2:    bar_color = BAR_CYAN;
      3'd3:    bar_color = BAR_GREEN;
      3'd4:    bar_color = BAR_MAGENTA;
      3'd5:    bar_color = BAR_RED;
      3'd6:    bar_color = BAR_BLUE;
      default: bar_color = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/ov7670_pattern_rom.sv
// Combinational test-pattern generator: (x, y, pattern, solid colour) -> RGB565 pixel.
module ov7670_pattern_rom
  import ov7670_stream_pkg::*;
#(
  parameter int H_ACTIVE = 320
) (
  input  logic [8:0]  x,
  input  logic [7:0]  y,
  input  pattern_t    pattern,
  input  logic [15:0] solid_color,
  output logic [15:0] pix
);

  localparam int BAR_W = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

  logic [8:0] bar_q_s;
  logic [2:0] bar_idx_s;
  logic       unused_y_s;

  assign unused_y_s = ^y[2:0];

  // Bar index; any remainder pixels fold into the last bar
  always_comb begin
    bar_q_s = x / 9'(BAR_W);
    if (bar_q_s > 9'd7) begin
      bar_idx_s = 3'd7;
    end else begin
      bar_idx_s = bar_q_s[2:0];
    end
  end

  // Pattern select
  always_comb begin
    case (pattern)
      PAT_BARS:     pix = bar_color(bar_idx_s);
      PAT_GRADIENT: pix = {x[8:4], x[8:3], y[7:3]};
      PAT_SOLID:    pix = solid_color;
      PAT_CHECKER:  pix = (x[4] ^ y[4]) ? RGB565_WHITE : RGB565_BLACK;
      default:      pix = RGB565_BLACK;
    endcase
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// OV7670 camera emulator: drives v_sync/href/data (RGB565, high byte first) for test-pattern frames.
module ov7670_stream_gen
  import ov7670_stream_pkg::*;
#(
  parameter int H_ACTIVE     = 320,
  parameter int H_BLANK      = 144,
  parameter int V_SYNC_LINES = 3,
  parameter int V_BP_LINES   = 17,
  parameter int V_ACTIVE     = 240,
  parameter int V_FP_LINES   = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        v_sync,
  output logic        href,
  output logic [7:0]  data,
  output logic        frame_done,
  output logic        busy,
  output logic [7:0]  frame_cnt
);

  localparam int LINE_CLKS = 2 * H_ACTIVE + H_BLANK;
  localparam int BW        = $clog2(LINE_CLKS);
  localparam int LW        = 9;
  localparam logic [BW-1:0] LAST_BYTE = BW'(LINE_CLKS - 1);
  localparam logic [BW-1:0] LAST_ACT  = BW'(2 * H_ACTIVE - 1);

  gen_state_t    state_r, nxt_state_s;
  logic [BW-1:0] byte_cnt_r, nxt_byte_s;
  logic [LW-1:0] line_cnt_r, nxt_line_s;
  pattern_t      pat_r;
  logic [15:0]   solid_r;
  logic [15:0]   pix_s;
  logic          line_end_s;
  logic          frame_end_s;

  assign line_end_s  = (byte_cnt_r == LAST_BYTE);
  assign frame_end_s = (nxt_state_s == ST_V_FP) && (nxt_byte_s == LAST_BYTE) &&
                       (nxt_line_s == LW'(V_FP_LINES - 1));

  // Next-state counters; outputs are registered from these so data lines up with href
  always_comb begin
    nxt_state_s = state_r;
    nxt_line_s  = line_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          nxt_state_s = ST_VSYNC;
          nxt_line_s  = {LW{1'b0}};
        end else begin
          nxt_state_s = ST_IDLE;
        end
      end
      ST_VSYNC: begin
        if (line_end_s && (line_cnt_r == LW'(V_SYNC_LINES - 1))) begin
          nxt_state_s = ST_V_BP;
          nxt_line_s  = {LW{1'b0}};
        end else if (line_end_s) begin
          nxt_line_s = line_cnt_r + LW'(1);
        end else begin
          nxt_line_s = line_cnt_r;
        end
      end
      ST_V_BP: begin
        if (line_end_s && (line_cnt_r == LW'(V_BP_LINES - 1))) begin
          nxt_state_s = ST_ACTIVE;
          nxt_line_s  = {LW{1'b0}};
        end else if (line_end_s) begin
          nxt_line_s = line_cnt_r + LW'(1);
        end else begin
          nxt_line_s = line_cnt_r;
        end
      end
      ST_ACTIVE: begin
        if (byte_cnt_r == LAST_ACT) begin
          nxt_state_s = ST_H_BLANK;
        end else begin
          nxt_state_s = ST_ACTIVE;
        end
      end
      ST_H_BLANK: begin
        if (line_end_s && (line_cnt_r == LW'(V_ACTIVE - 1))) begin
          nxt_state_s = ST_V_FP;
          nxt_line_s  = {LW{1'b0}};
        end else if (line_end_s) begin
          nxt_state_s = ST_ACTIVE;
          nxt_line_s  = line_cnt_r + LW'(1);
        end else begin
          nxt_state_s = ST_H_BLANK;
        end
      end
      ST_V_FP: begin
        if (line_end_s && (line_cnt_r == LW'(V_FP_LINES - 1))) begin
          nxt_state_s = enable ? ST_VSYNC : ST_IDLE;
          nxt_line_s  = {LW{1'b0}};
        end else if (line_end_s) begin
          nxt_line_s = line_cnt_r + LW'(1);
        end else begin
          nxt_line_s = line_cnt_r;
        end
      end
      default: begin
        nxt_state_s = ST_IDLE;
        nxt_line_s  = {LW{1'b0}};
      end
    endcase

    if (nxt_state_s == ST_IDLE || state_r == ST_IDLE || line_end_s) begin
      nxt_byte_s = {BW{1'b0}};
    end else begin
      nxt_byte_s = byte_cnt_r + BW'(1);
    end
  end

  ov7670_pattern_rom #(
    .H_ACTIVE (H_ACTIVE)
  ) u_rom (
    .x           (9'(nxt_byte_s >> 1)),
    .y           (nxt_line_s[7:0]),
    .pattern     (pat_r),
    .solid_color (solid_r),
    .pix         (pix_s)
  );

  // FSM state, frame configuration latch and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      byte_cnt_r <= {BW{1'b0}};
      line_cnt_r <= {LW{1'b0}};
      pat_r      <= PAT_BARS;
      solid_r    <= 16'h0000;
      v_sync     <= 1'b0;
      href       <= 1'b0;
      data       <= 8'h00;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 8'h00;
    end else begin
      state_r    <= nxt_state_s;
      byte_cnt_r <= nxt_byte_s;
      line_cnt_r <= nxt_line_s;
      if (nxt_state_s == ST_VSYNC && state_r != ST_VSYNC) begin
        pat_r   <= pattern_t'(pattern_sel);
        solid_r <= solid_color;
      end
      v_sync     <= (nxt_state_s == ST_VSYNC);
      href       <= (nxt_state_s == ST_ACTIVE);
      data       <= (nxt_state_s == ST_ACTIVE) ? (nxt_byte_s[0] ? pix_s[7:0] : pix_s[15:8]) : 8'h00;
      frame_done <= frame_end_s;
      busy       <= (nxt_state_s != ST_IDLE);
      if (frame_end_s) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Scoreboard bench for ov7670_stream_gen: a cycle model pushes expected outputs, a negedge monitor pops and compares.
module tb_ov7670_stream_gen;

  localparam int H_ACTIVE     = 320;
  localparam int H_BLANK      = 4;
  localparam int V_SYNC_LINES = 1;
  localparam int V_BP_LINES   = 1;
  localparam int V_ACTIVE     = 17;
  localparam int V_FP_LINES   = 1;
  localparam int LINE_CLKS    = 2 * H_ACTIVE + H_BLANK;
  localparam int FRAME_CLKS   = (V_SYNC_LINES + V_BP_LINES + V_ACTIVE + V_FP_LINES) * LINE_CLKS;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_color;
  logic        v_sync, href, frame_done, busy;
  logic [7:0]  data, frame_cnt;

  always #5 clk = ~clk;

  ov7670_stream_gen #(
    .H_ACTIVE     (H_ACTIVE),
    .H_BLANK      (H_BLANK),
    .V_SYNC_LINES (V_SYNC_LINES),
    .V_BP_LINES   (V_BP_LINES),
    .V_ACTIVE     (V_ACTIVE),
    .V_FP_LINES   (V_FP_LINES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .solid_color (solid_color),
    .v_sync      (v_sync),
    .href        (href),
    .data        (data),
    .frame_done  (frame_done),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  typedef struct packed {
    logic       v_sync;
    logic       href;
    logic [7:0] data;
    logic       frame_done;
    logic       busy;
    logic [7:0] frame_cnt;
  } obs_t;

  obs_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  logic [7:0] cap [0:3][0:639];
  int         idle_nz = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pix(input int x, input int y, input logic [1:0] pat,
                                          input logic [15:0] solid);
    int bar;
    logic [8:0] xv;
    logic [7:0] yv;
    xv  = x[8:0];
    yv  = y[7:0];
    bar = x / (H_ACTIVE / 8);
    if (bar > 7) bar = 7;
    case (pat)
      2'd0: begin
        case (bar)
          0:       exp_pix = 16'hFFFF;
          1:       exp_pix = 16'hFFE0;
          2:       exp_pix = 16'h07FF;
          3:       exp_pix = 16'h07E0;
          4:       exp_pix = 16'hF81F;
          5:       exp_pix = 16'hF800;
          6:       exp_pix = 16'h001F;
          default: exp_pix = 16'h0000;
        endcase
      end
      2'd1:    exp_pix = {xv[8:4], xv[8:3], yv[7:3]};
      2'd2:    exp_pix = solid;
      default: exp_pix = (xv[4] ^ yv[4]) ? 16'hFFFF : 16'h0000;
    endcase
  endfunction

  // Reference model: frame position counter advanced on each rising edge
  initial begin : model
    bit          m_active;
    int          m_pos, line, col, y;
    logic [1:0]  m_pat;
    logic [15:0] m_solid, p;
    logic [7:0]  m_cnt;
    obs_t        e;
    m_active = 1'b0;
    m_pos    = 0;
    m_cnt    = 8'h00;
    m_pat    = 2'd0;
    m_solid  = 16'h0000;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_active = 1'b0;
        m_cnt    = 8'h00;
        sb_q.delete();
      end else begin
        if (!m_active) begin
          if (enable) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_pat    = pattern_sel;
            m_solid  = solid_color;
          end
        end else if (m_pos == FRAME_CLKS - 1) begin
          if (enable) begin
            m_pos   = 0;
            m_pat   = pattern_sel;
            m_solid = solid_color;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_pos++;
        end
        e = '0;
        if (m_active) begin
          line     = m_pos / LINE_CLKS;
          col      = m_pos % LINE_CLKS;
          y        = line - V_SYNC_LINES - V_BP_LINES;
          e.busy   = 1'b1;
          e.v_sync = (line < V_SYNC_LINES);
          if (y >= 0 && y < V_ACTIVE && col < 2 * H_ACTIVE) begin
            p      = exp_pix(col / 2, y, m_pat, m_solid);
            e.href = 1'b1;
            e.data = (col % 2 == 1) ? p[7:0] : p[15:8];
          end
          if (m_pos == FRAME_CLKS - 1) begin
            m_cnt++;
            e.frame_done = 1'b1;
          end
        end
        e.frame_cnt = m_cnt;
        sb_q.push_back(e);
      end
    end
  end

  // Monitor: scoreboard compare plus per-frame href/v_sync statistics and byte capture
  initial begin : monitor
    obs_t e;
    int   fr, hline, bidx, run, hpulses, vs_clks, ci;
    logic prev_vs, prev_href;
    fr = 0; hline = -1; bidx = 0; run = 0; hpulses = 0; vs_clks = 0;
    prev_vs = 1'b0; prev_href = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_vs   = 1'b0;
        prev_href = 1'b0;
      end else if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_val("cycle", {v_sync, href, data, frame_done, busy, frame_cnt}, e);
        if (v_sync && !prev_vs) begin
          fr++; hline = -1; hpulses = 0; vs_clks = 0;
        end
        if (v_sync) vs_clks++;
        if (href && !prev_href) begin
          hline++; hpulses++; bidx = 0; run = 0;
        end
        if (href) begin
          ci = -1;
          if (fr == 1 && hline == 0) ci = 0;
          if (fr == 2 && hline == 0) ci = 1;
          if (fr == 2 && hline == 16) ci = 2;
          if (fr == 3 && hline == 0) ci = 3;
          if (ci >= 0 && bidx < 640) cap[ci][bidx] = data;
          bidx++; run++;
        end
        if (!href && prev_href) check_val("href_run", run, 2 * H_ACTIVE);
        if (!href && data != 8'h00) idle_nz++;
        if (frame_done) begin
          check_val("href_pulses", hpulses, V_ACTIVE);
          check_val("vsync_clks", vs_clks, V_SYNC_LINES * LINE_CLKS);
        end
        prev_vs   = v_sync;
        prev_href = href;
      end
    end
  end

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!frame_done && n < bound) begin
      @(negedge clk);
      n++;
    end
    check_val("frame_done_seen", frame_done, 1'b1);
  endtask

  // Stimulus sequence
  initial begin : stim
    int vs_seen;
    reset       = 1'b1;
    enable      = 1'b0;
    pattern_sel = 2'd0;
    solid_color = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs", {v_sync, href, data, frame_done, busy, frame_cnt}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    enable = 1'b1;

    // Frame 1: colour bars, pattern changed mid-frame takes effect next frame
    repeat (FRAME_CLKS / 2) @(negedge clk);
    pattern_sel = 2'd3;
    wait_done(FRAME_CLKS + 10);
    check_val("frame_cnt_f1", frame_cnt, 8'd1);

    // Frame 2: checkerboard, enable dropped mid-active
    repeat ((V_SYNC_LINES + V_BP_LINES + 10) * LINE_CLKS + 51) @(negedge clk);
    enable = 1'b0;
    wait_done(FRAME_CLKS + 10);
    check_val("frame_cnt_f2", frame_cnt, 8'd2);
    @(negedge clk);
    check_val("busy_idle", busy, 1'b0);
    vs_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (v_sync || busy) vs_seen++;
    end
    check_val("no_restart", vs_seen, 0);

    // Frame 3: solid colour, aborted by reset during active
    pattern_sel = 2'd2;
    solid_color = 16'hABCD;
    enable      = 1'b1;
    repeat ((V_SYNC_LINES + V_BP_LINES + 1) * LINE_CLKS + 100) @(negedge clk);
    check_val("href_before_rst", href, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("async_reset", {v_sync, href, data, frame_done, busy, frame_cnt}, 32'h0);
    sb_q.delete();
    pattern_sel = 2'd1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;

    // Frame 4: gradient after reset, counter restarts at zero
    @(negedge clk);
    wait_done(FRAME_CLKS + 20);
    check_val("frame_cnt_after_rst", frame_cnt, 8'd1);
    enable = 1'b0;
    repeat (5) @(negedge clk);

    check_val("bars_p0_hi", cap[0][0], 8'hFF);
    check_val("bars_p0_lo", cap[0][1], 8'hFF);
    check_val("bars_p40_hi", cap[0][80], 8'hFF);
    check_val("bars_p40_lo", cap[0][81], 8'hE0);
    check_val("bars_p319_hi", cap[0][638], 8'h00);
    check_val("bars_p319_lo", cap[0][639], 8'h00);
    check_val("chk_16_0", {cap[1][32], cap[1][33]}, 16'hFFFF);
    check_val("chk_16_16", {cap[2][32], cap[2][33]}, 16'h0000);
    check_val("solid_hi", cap[3][0], 8'hAB);
    check_val("solid_lo", cap[3][1], 8'hCD);
    check_val("idle_data_zero", idle_nz, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
